non_hwt_pipe: RTL and testbench

NON_HWT_PIPE -- requirements
Module: non_hwt_pipe

---
 rtl/non_hwt_pipe.sv | 104 ++++++++++
 tb/tb_non_hwt_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/non_hwt_pipe.sv
// Elastic valid/ready pipeline computing Y = D & ((A & B) | C) per lane, with a
// saturating counter of result bits that leave the block.
module non_hwt_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  input  logic             clr_count,
  output logic [CNT_W-1:0] hit_count
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = CNT_W + PC_W;

  logic [STAGES-1:0]            r_valid;
  logic [STAGES-1:0][WIDTH-1:0] r_data;
  logic [CNT_W-1:0]             r_hit;

  logic [STAGES-1:0] w_adv;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [WIDTH-1:0]  w_result;
  logic [PC_W-1:0]   w_pop;
  logic [SUM_W-1:0]  w_sum;
  logic [CNT_W-1:0]  w_sat;

  // A slot moves on when the slot ahead is empty or is itself moving on; the
  // chain is resolved from the output end backwards.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned and infers a latch.
    w_adv             = '0;
    w_adv[STAGES-1]   = r_valid[STAGES-1] & out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      w_adv[i] = r_valid[i] & (~r_valid[i+1] | w_adv[i+1]);
    end
  end

  assign in_ready   = ~r_valid[0] | w_adv[0];
  assign w_in_xfer  = in_valid & in_ready;
  assign out_valid  = r_valid[STAGES-1];
  assign Y          = r_data[STAGES-1];
  assign w_out_xfer = out_valid & out_ready;
  assign w_result   = D & ((A & B) | C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      // NOTE: the data slots are cleared as well so Y reads 0 straight out of reset.
      r_data  <= '0;
    end else begin
      // NOTE: non-blocking updates let every slot see its neighbour's pre-edge value.
      if (w_in_xfer) begin
        r_valid[0] <= 1'b1;
        r_data[0]  <= w_result;
      end else if (w_adv[0]) begin
        r_valid[0] <= 1'b0;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_adv[i-1]) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= r_data[i-1];
        end else if (w_adv[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + PC_W'(Y[i]);
    end
  end

  // The sum is kept one popcount-width wider than the counter so overflow is
  // visible before it is clamped.
  assign w_sum = SUM_W'(r_hit) + SUM_W'(w_pop);
  assign w_sat = (w_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit <= '0;
    end else if (clr_count) begin
      r_hit <= '0;
    end else if (w_out_xfer) begin
      r_hit <= w_sat;
    end
  end

  assign hit_count = r_hit;

endmodule

// File: tb/tb_non_hwt_pipe.sv
// Bench for non_hwt_pipe: four instances (STAGES 2/1/3/8) each checked every cycle
// against an in-order queue model; instance 0 also gets directed literal checks.
module tb_non_hwt_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [3:0] y;
    int         acc;
  } item_t;

  function automatic int st_of(int k);
    case (k)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      default: return 8;
    endcase
  endfunction

  function automatic int cw_of(int k);
    return (k == 0) ? 4 : 16;
  endfunction

  function automatic logic [3:0] ref_y(input logic [3:0] a, b, c, d);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = d[i] && ((a[i] && b[i]) || c[i]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  for (genvar k = 0; k < 4; k++) begin : g_inst
    localparam int ST = st_of(k);
    localparam int CW = cw_of(k);

    logic          rst_n, in_valid, in_ready, out_valid, out_ready, clr;
    logic [3:0]    a, b, c, d, y;
    logic [CW-1:0] hc;

    non_hwt_pipe #(.WIDTH(4), .STAGES(ST), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a),
      .B         (b),
      .C         (c),
      .D         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (y),
      .clr_count (clr),
      .hit_count (hc)
    );

    item_t  q[$];
    longint hc_m  = 0;
    int     n_out = 0;

    // Reference: in-flight items in acceptance order; the oldest becomes
    // visible once it is ST cycles old, and input is refused only when the
    // pipe is full and the output is stalled.
    always @(negedge clk) begin : model
      bit     exp_ov, exp_ir, in_x, out_x;
      item_t  it;
      longint mx;
      mx = (longint'(1) << CW) - 1;
      if (!rst_n) begin
        q.delete();
        hc_m = 0;
        check($sformatf("i%0d.rst_out_valid", k), out_valid, 0);
        check($sformatf("i%0d.rst_in_ready", k), in_ready, 1);
        check($sformatf("i%0d.rst_hit_count", k), 32'(hc), 0);
        check($sformatf("i%0d.rst_y", k), y, 0);
      end else begin
        exp_ov = (q.size() > 0) && (cyc - q[0].acc >= ST);
        exp_ir = out_ready || (q.size() < ST);
        check($sformatf("i%0d.out_valid", k), out_valid, exp_ov);
        check($sformatf("i%0d.in_ready", k), in_ready, exp_ir);
        check($sformatf("i%0d.hit_count", k), 32'(hc), 32'(hc_m));
        if (exp_ov) check($sformatf("i%0d.y", k), y, q[0].y);
        in_x  = in_valid && exp_ir;
        out_x = exp_ov && out_ready;
        if (out_x) begin
          it = q.pop_front();
          n_out++;
          hc_m = hc_m + $countones(it.y);
          if (hc_m > mx) hc_m = mx;
        end
        if (clr) hc_m = 0;
        if (in_x) begin
          it.y   = ref_y(a, b, c, d);
          it.acc = cyc;
          q.push_back(it);
        end
      end
    end

    if (k == 0) begin : g_dir
      logic [3:0]    got[$];
      logic [CW-1:0] hq[$];
      bit            pend = 1'b0;
      logic [15:0]   tt   = 16'hF800;

      // Records each result that leaves, and the counter value just after it.
      always @(negedge clk) begin
        if (pend) hq.push_back(hc);
        pend = rst_n && out_valid && out_ready;
        if (pend) got.push_back(y);
      end

      task automatic idle(input int n);
        repeat (n) begin
          @(posedge clk);
          #1;
        end
      endtask

      task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
          @(negedge clk);
          if (in_ready) ok = 1'b1;
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
        check("i0.accept", ok, 1);
      endtask

      task automatic send(input logic [3:0] ta, tb, tc, td);
        a = ta; b = tb; c = tc; d = td;
        in_valid = 1'b1;
        wait_accept();
      endtask

      initial begin
        logic [3:0] va, vb, vc, vd;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        @(posedge clk);
        #2;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_hit_count", 32'(hc), 0);
        check("reset_y", y, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single all-ones set: visible exactly two cycles after acceptance.
        out_ready = 1'b1;
        a = 4'hF; b = 4'hF; c = 4'h0; d = 4'hF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_out_valid", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_cycle2_out_valid", out_valid, 1);
        check("lat_cycle2_y", y, 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("lat_hit_count", 32'(hc), 4);
        check("lat_drained", out_valid, 0);
        idle(1);

        // Function patterns and the full per-lane truth-table sweep.
        got.delete();
        send(4'h5, 4'h3, 4'h8, 4'hE);
        send(4'h0, 4'h0, 4'hF, 4'h0);
        for (int s = 0; s < 4; s++) begin
          for (int i = 0; i < 4; i++) begin
            int j;
            j = 4 * s + i;
            va[i] = j[0]; vb[i] = j[1]; vc[i] = j[2]; vd[i] = j[3];
          end
          send(va, vb, vc, vd);
        end
        idle(6);
        check("func_count", got.size(), 6);
        check("func_y_5_3_8_e", got[0], 4'h8);
        check("func_y_0_0_f_0", got[1], 4'h0);
        for (int s = 0; s < 4; s++) check($sformatf("sweep_%0d", s), got[2+s], tt[4*s +: 4]);
        check("func_hit_count", 32'(hc), 10);

        // Backpressure: two sets fill the pipe, the third waits.
        got.delete();
        out_ready = 1'b0;
        send(4'hF, 4'hF, 4'h0, 4'hF);
        send(4'h0, 4'h0, 4'h3, 4'hF);
        a = 4'h6; b = 4'h4; c = 4'h1; d = 4'h7; in_valid = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
          check("bp_y_stable", y, 4'hF);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        wait_accept();
        idle(6);
        check("bp_count", got.size(), 3);
        check("bp_order0", got[0], 4'hF);
        check("bp_order1", got[1], 4'h3);
        check("bp_order2", got[2], 4'h5);
        check("bp_hit_saturated", 32'(hc), 15);

        // Saturation sequence, then a clear that coincides with a transfer.
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        check("clr_hit_count", 32'(hc), 0);
        hq.delete();
        repeat (5) send(4'hF, 4'hF, 4'h0, 4'hF);
        idle(4);
        a = 4'hF; b = 4'hF; c = 4'h0; d = 4'hF; in_valid = 1'b1;
        idle(1);
        in_valid = 1'b0;
        idle(1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        idle(2);
        check("sat_count", hq.size(), 6);
        check("sat_0", 32'(hq[0]), 4);
        check("sat_1", 32'(hq[1]), 8);
        check("sat_2", 32'(hq[2]), 12);
        check("sat_3", 32'(hq[3]), 15);
        check("sat_4", 32'(hq[4]), 15);
        check("sat_clr_wins", 32'(hq[5]), 0);

        // Reset with both slots full discards everything in flight.
        send(4'h0, 4'h0, 4'h1, 4'h1);
        idle(3);
        check("pre_rst_hit_count", 32'(hc), 1);
        out_ready = 1'b0;
        send(4'hF, 4'hF, 4'h0, 4'hF);
        send(4'h0, 4'h0, 4'hF, 4'hF);
        idle(1);
        @(negedge clk);
        check("pre_rst_full_valid", out_valid, 1);
        check("pre_rst_full_ready", in_ready, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_hit_count", 32'(hc), 0);
        check("mid_rst_y", y, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
        out_ready = 1'b1;
        send(4'h0, 4'h0, 4'h2, 4'h2);
        idle(5);
        check("post_rst_count", got.size(), 1);
        check("post_rst_y", got[0], 4'h2);
        check("post_rst_hit_count", 32'(hc), 1);
        done_cnt++;
      end
    end else begin : g_rnd
      initial begin
        int thr;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        thr = 8;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int t = 0; t < 40000 && n_out < 10000; t++) begin
          if (t % 256 == 0) thr = $urandom_range(8, 2);
          in_valid  = ($urandom_range(3) != 0);
          a         = 4'($urandom);
          b         = 4'($urandom);
          c         = 4'($urandom);
          d         = 4'($urandom);
          out_ready = ($urandom_range(7) < thr);
          clr       = ($urandom_range(127) == 0);
          @(posedge clk);
          #1;
        end
        check($sformatf("i%0d.transfers_done", k), n_out >= 10000, 1);
        done_cnt++;
      end
    end
  end

  initial begin
    for (int t = 0; t < 60000 && done_cnt < 4; t++) @(posedge clk);
    check("all_processes_done", done_cnt, 4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
